// File: rtl/i2c_slave_sync.sv
// I2C slave running entirely on the system clock: synchronised and glitch-filtered SCL/SDA,
// START/Sr/STOP detection, 1- or 2-byte register pointer, optional clock stretching on reads.
module i2c_slave_sync #(
    parameter logic [6:0] SLAVE_ADDR = 7'h18,
    parameter int         ADDR_BYTES = 1,
    parameter int         FILT_LEN   = 3,
    parameter int         STRETCH_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    scl_oe,
    output logic                    sda_oe,
    output logic [8*ADDR_BYTES-1:0] reg_addr,
    output logic [7:0]              wr_data,
    output logic                    write,
    output logic                    rd_req,
    input  logic [7:0]              rd_data,
    input  logic                    rd_valid,
    output logic                    busy
);
    localparam int AW = 8*ADDR_BYTES;
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RLOAD, RDATA, RACK, IGNORE
    } state_t;

    // index 1 = SCL, index 0 = SDA; idle bus is high so everything resets to 1
    logic [1:0]         s1, s2, filt, filt_q;
    logic [1:0][CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '1;
            s2     <= '1;
            filt   <= '1;
            filt_q <= '1;
            cnt    <= '0;
        end else begin
            s1     <= {scl_in, sda_in};
            s2     <= s1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT_LEN-1)) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda;
    assign sda      = filt[0];
    assign scl_rise = filt[1] & ~filt_q[1];
    assign scl_fall = ~filt[1] & filt_q[1];
    assign start_c  = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    assign stop_c   = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [6:0]    shreg;
    logic [6:0]    rd_byte;
    logic [1:0]    ptr_idx;
    logic          rd_mode, ld_phase;
    logic [7:0]    byte_in;
    logic [AW-1:0] ptr_next;

    assign byte_in = {shreg, sda};

    // pointer bytes arrive MSB first, so each new byte shifts in at the bottom
    if (ADDR_BYTES > 1) begin : g_wide
        assign ptr_next = {reg_addr[AW-9:0], byte_in};
    end else begin : g_narrow
        assign ptr_next = byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            rd_byte  <= '0;
            ptr_idx  <= '0;
            rd_mode  <= 1'b0;
            ld_phase <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            reg_addr <= '0;
            wr_data  <= '0;
            write    <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            write  <= 1'b0;
            rd_req <= 1'b0;
            if (write) reg_addr <= reg_addr + 1'b1;
            if (scl_rise) begin
                shreg   <= byte_in[6:0];
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (stop_c) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                scl_oe <= 1'b0;
            end else if (start_c) begin
                state   <= DEV_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                scl_oe  <= 1'b0;
            end else begin
                case (state)
                    DEV_ADDR: if (scl_rise && bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            state   <= DEV_ACK;
                            busy    <= 1'b1;
                            rd_mode <= byte_in[0];
                        end else begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end
                    end
                    PTR: if (scl_rise && bit_cnt == 4'd7) begin
                        bit_cnt  <= '0;
                        reg_addr <= ptr_next;
                        state    <= PTR_ACK;
                    end
                    WDATA: if (scl_rise && bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        wr_data <= byte_in;
                        write   <= 1'b1;
                        state   <= WDATA_ACK;
                    end
                    // first fall after the 8th bit drives ACK, the next one ends the slot
                    DEV_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == DEV_ACK && rd_mode) begin
                                state    <= RLOAD;
                                rd_req   <= 1'b1;
                                scl_oe   <= (STRETCH_EN != 0);
                                ld_phase <= 1'b0;
                            end else if (state == DEV_ACK) begin
                                state   <= PTR;
                                ptr_idx <= '0;
                            end else if (state == PTR_ACK && ptr_idx != 2'(ADDR_BYTES-1)) begin
                                state   <= PTR;
                                ptr_idx <= ptr_idx + 1'b1;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RLOAD: begin
                        if (!ld_phase) begin
                            ld_phase <= 1'b1;
                        end else if (STRETCH_EN == 0 || rd_valid) begin
                            rd_byte <= rd_data[6:0];
                            sda_oe  <= ~rd_data[7];
                            scl_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise && bit_cnt == 4'd7) reg_addr <= reg_addr + 1'b1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RACK;
                            end else begin
                                sda_oe  <= ~rd_byte[6];
                                rd_byte <= {rd_byte[5:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise && sda) begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end else if (scl_fall) begin
                            state    <= RLOAD;
                            rd_req   <= 1'b1;
                            scl_oe   <= (STRETCH_EN != 0);
                            ld_phase <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
